led_seq: RTL and testbench
==========================

# led_seq

Parametrised LED pattern sequencer for board status and demo outputs. It drives `LED_NUM` LEDs through one of four selectable patterns: shift-left, shift-right, bounce and fill. The step period is programmable, and a run/pause input and output polarity selection are provided. The block sits directly between the board clock/reset and the LED pins, and supersedes the fixed 4-LED left-shift water light.

## Interface
- `LED_NUM`, 4: number of LEDs; legal range 2..32.
- `CNT_W`, 25: prescaler counter width.
- `CNT_MAX`, 25'd11_999_999: prescaler terminal value; step period is `CNT_MAX+1` clocks.
- `ACTIVE_LOW`, 0: when 1, the LED output is inverted (a 0 on the pin lights the LED).
- `clk`  input  1  system clock; all logic runs in this single clock domain.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `en`  input  1  run enable; 0 pauses the prescaler and holds the pattern.
- `mode`  input  2  pattern select: 0 SHIFT_L, 1 SHIFT_R, 2 BOUNCE, 3 FILL.
- `led_out`  output  LED_NUM  LED drive, `pat ^ {LED_NUM{ACTIVE_LOW}}`, registered.
- `step_tick`  output  1  one-cycle pulse, coincident with each new pattern value.
- `wrap`  output  1  one-cycle pulse when a step reloads the start pattern after a full cycle.

## Operation
- **Prescaler `cnt` (CNT_W bits)**
  - Counts 0..CNT_MAX and wraps to 0.
  - Increments only while `en`=1; holds while `en`=0.
  - Internal `adv` = `en && cnt==CNT_MAX`.
- **Pattern register `pat` (LED_NUM bits)**
  - Reset value is all-zero (LEDs off).
  - Updates only on `adv`.
- **Direction bit `dir`**: used in BOUNCE only; 0 = moving up, 1 = moving down.
- **Flag `started`**
  - Cleared on reset and on mode change.
  - Set on the first `adv`.
- **Start pattern**
  - SHIFT_R: MSB only, 10..0.
  - All other modes: LSB only, 0..01.
- **Next-pattern rules**
  - If `pat`=0 (any mode): load the start pattern.
  - SHIFT_L: `pat<<1`; from MSB, go to 0..01.
  - SHIFT_R: `pat>>1`; from LSB, go to 10..0.
  - BOUNCE:
    - Shift left while `dir`=0. On reaching the MSB, set `dir`=1.
    - Shift right while `dir`=1. On reaching the LSB, set `dir`=0.
    - Cycle length is 2·LED_NUM−2 steps.
  - FILL: `(pat<<1)|1` until all-ones, then all-zero, then 0..01. Cycle length is LED_NUM+1 steps.
- **Mode change**
  - Registered `mode_q` is compared with `mode` every cycle.
  - On a mismatch: `mode_q`←`mode`, `cnt`←0, `pat`←0, `dir`←0, `started`←0.
  - Mode change takes priority over `adv` in that same cycle.
- **Outputs**
  - `step_tick` is the registered `adv`, so it is high in the cycle the new `pat` is visible.
  - `wrap` is registered, set when `adv` loads the start pattern and `started` was already 1.
  - The first load after reset or mode change does not assert `wrap`.

## Timing
- **Reset values**
  - `led_out` = all-zero if `ACTIVE_LOW`=0, all-ones if 1.
  - `step_tick`=0, `wrap`=0, `cnt`=0, `mode_q`=0.
- **After reset release with `en`=1**: the first pattern appears at clock edge CNT_MAX+1, followed by one step every CNT_MAX+1 clocks.
- **Pause**
  - `en` falling in the cycle where `cnt`==CNT_MAX suppresses that step.
  - On resume, counting continues from the held `cnt`, so no step is lost or duplicated.
- **`CNT_MAX`=0**: step every clock while `en`=1.
- **Mode change latency**: `pat`=0 at the next edge; the first new-mode pattern follows CNT_MAX+1 enabled clocks later.
- **Reset mid-operation**: all state returns to reset values immediately (asynchronous); no partial step is produced.

## Test plan
All scenarios use LED_NUM=4 and CNT_MAX=3.
- **SHIFT_L wrap**
  - Stimulus: reset, `en`=1, mode 0.
  - Required: `led_out` 0000, then 0001 at edge 4, then 0010, 0100, 1000, 0001 every 4 clocks.
  - `step_tick` pulses at each change; `wrap` pulses only with the second 0001.
- **SHIFT_R, BOUNCE, FILL sequences**
  - Mode 1: 1000, 0100, 0010, 0001, 1000.
  - Mode 2: 0001, 0010, 0100, 1000, 0100, 0010, 0001 (`wrap` here).
  - Mode 3: 0001, 0011, 0111, 1111, 0000, 0001 (`wrap` here).
- **Pause**
  - Stimulus: drop `en` for 10 clocks at `cnt`=2.
  - Required: pattern and `cnt` frozen, no `step_tick`; after resume, the next step arrives 2 clocks later.
- **Mode change mid-sequence**
  - Stimulus: switch 0→2 while `pat`=0100.
  - Required: `pat`=0000 next clock; 0001 appears 4 clocks later with no `wrap`.
- **Mode change colliding with `adv`**
  - Stimulus: change mode in the same cycle as `adv`.
  - Required: no step and no `step_tick`; pattern clears.
- **Polarity and reset**
  - `ACTIVE_LOW`=1: reset gives `led_out`=1111; first step gives 1110.
  - Asserting `rst_n` mid-step returns all outputs to reset values asynchronously.

Source files
------------

// File: rtl/led_seq.sv
// LED pattern sequencer: prescaled stepping through shift-left, shift-right,
// bounce and fill patterns, with run/pause and selectable output polarity.
module led_seq #(
    parameter int unsigned      LED_NUM    = 4,
    parameter int unsigned      CNT_W      = 25,
    parameter logic [CNT_W-1:0] CNT_MAX    = 25'd11_999_999,
    parameter bit               ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    output logic [LED_NUM-1:0] led_out,
    output logic               step_tick,
    output logic               wrap
);

    typedef enum logic [1:0] {
        MODE_SHIFT_L = 2'd0,
        MODE_SHIFT_R = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_FILL    = 2'd3
    } mode_t;

    localparam logic [LED_NUM-1:0] PAT_LSB  = LED_NUM'(1);
    localparam logic [LED_NUM-1:0] PAT_MSB  = {1'b1, {(LED_NUM-1){1'b0}}};
    localparam logic [LED_NUM-1:0] PAT_ONES = {LED_NUM{1'b1}};
    localparam logic [LED_NUM-1:0] POL_MASK = {LED_NUM{ACTIVE_LOW}};

    logic [CNT_W-1:0]   cnt;
    mode_t              mode_q;
    logic [LED_NUM-1:0] pat;
    logic               dir;
    logic               started;

    logic               adv;
    logic               mode_chg;
    logic [LED_NUM-1:0] start_pat;
    logic [LED_NUM-1:0] pat_nxt;
    logic               dir_nxt;

    assign adv       = en && (cnt == CNT_MAX);
    assign mode_chg  = (mode_t'(mode) != mode_q);
    assign start_pat = (mode_q == MODE_SHIFT_R) ? PAT_MSB : PAT_LSB;

    // Next pattern and bounce direction for the current mode.
    always_comb begin
        pat_nxt = start_pat;
        dir_nxt = dir;
        if (pat == '0) begin
            pat_nxt = start_pat;
            dir_nxt = 1'b0;
        end else begin
            case (mode_q)
                MODE_SHIFT_L: pat_nxt = pat[LED_NUM-1] ? PAT_LSB : (pat << 1);
                MODE_SHIFT_R: pat_nxt = pat[0] ? PAT_MSB : (pat >> 1);
                MODE_BOUNCE: begin
                    if (!dir) begin
                        pat_nxt = pat << 1;
                        if (pat_nxt == PAT_MSB) dir_nxt = 1'b1;
                    end else begin
                        pat_nxt = pat >> 1;
                        if (pat_nxt == PAT_LSB) dir_nxt = 1'b0;
                    end
                end
                MODE_FILL: pat_nxt = (pat == PAT_ONES) ? '0 : ((pat << 1) | PAT_LSB);
                default: pat_nxt = start_pat;
            endcase
        end
    end

    // Prescaler, pattern state and registered outputs; mode change beats a step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mode_q    <= MODE_SHIFT_L;
            pat       <= '0;
            dir       <= 1'b0;
            started   <= 1'b0;
            led_out   <= POL_MASK;
            step_tick <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            step_tick <= 1'b0;
            wrap      <= 1'b0;
            if (mode_chg) begin
                mode_q  <= mode_t'(mode);
                cnt     <= '0;
                pat     <= '0;
                dir     <= 1'b0;
                started <= 1'b0;
                led_out <= POL_MASK;
            end else begin
                if (en) begin
                    cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
                end
                if (adv) begin
                    pat       <= pat_nxt;
                    dir       <= dir_nxt;
                    started   <= 1'b1;
                    led_out   <= pat_nxt ^ POL_MASK;
                    step_tick <= 1'b1;
                    wrap      <= started && (pat_nxt == start_pat);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_seq.sv
// Scoreboard bench for led_seq: a sequence-table model queues expected steps,
// a negedge monitor checks every step pulse and the LED state each cycle.
module tb_led_seq;

    localparam int unsigned      N  = 4;
    localparam int unsigned      CW = 4;
    localparam logic [CW-1:0]    CM = 4'd3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [N-1:0] led_a, led_b;
    logic         tick_a, tick_b, wrap_a, wrap_b;

    led_seq #(.LED_NUM(N), .CNT_W(CW), .CNT_MAX(CM), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .led_out(led_a), .step_tick(tick_a), .wrap(wrap_a));

    led_seq #(.LED_NUM(N), .CNT_W(CW), .CNT_MAX(CM), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .led_out(led_b), .step_tick(tick_b), .wrap(wrap_b));

    always #5 clk = ~clk;

    typedef struct {
        longint       t;
        logic [N-1:0] led;
        logic         w;
    } step_t;

    step_t q[$];
    int errors = 0;
    int checks = 0;

    // Reference model state: position in the mode's pattern cycle.
    int           m_mode_q = 0;
    int           m_cnt = 0;
    int           m_idx = -1;
    bit           m_started = 1'b0;
    logic [N-1:0] m_led = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int seq_len(input int md);
        case (md)
            2:       return 2 * N - 2;
            3:       return N + 1;
            default: return N;
        endcase
    endfunction

    function automatic logic [N-1:0] seq_pat(input int md, input int idx);
        int v;
        case (md)
            0:       v = 1 << idx;
            1:       v = 1 << (N - 1 - idx);
            2:       v = (idx < N) ? (1 << idx) : (1 << (2 * N - 2 - idx));
            default: v = (idx < N) ? ((1 << (idx + 1)) - 1) : 0;
        endcase
        return N'(v);
    endfunction

    function automatic void model_reset();
        m_mode_q = 0; m_cnt = 0; m_idx = -1; m_started = 1'b0; m_led = '0;
    endfunction

    // Apply one clock edge to the model with the inputs the DUT just sampled.
    function automatic void model_edge(input logic e, input logic [1:0] md, input longint t);
        step_t s;
        if (int'(md) != m_mode_q) begin
            m_mode_q = int'(md);
            m_cnt = 0; m_idx = -1; m_started = 1'b0; m_led = '0;
        end else if (e) begin
            if (m_cnt == int'(CM)) begin
                m_cnt = 0;
                m_idx = (m_idx < 0) ? 0 : (m_idx + 1) % seq_len(m_mode_q);
                s.w = m_started && (m_idx == 0);
                m_started = 1'b1;
                m_led = seq_pat(m_mode_q, m_idx);
                s.t = t;
                s.led = m_led;
                q.push_back(s);
            end else begin
                m_cnt++;
            end
        end
    endfunction

    task automatic step(input logic e, input logic [1:0] md);
        en = e;
        mode = md;
        @(posedge clk);
        model_edge(e, md, longint'($time));
        #1;
    endtask

    // Monitor: compare each presented step and the held LED state every cycle.
    always @(negedge clk) begin : monitor
        step_t s;
        logic [N-1:0] inv;
        if (rst_n) begin
            inv = ~m_led;
            check("led_a", 64'(led_a), 64'(m_led));
            check("led_b", 64'(led_b), 64'(inv));
            while (q.size() > 0 && q[0].t < longint'($time) - 5) begin
                s = q.pop_front();
                check("missed_step_time", 64'(longint'($time) - 5), 64'(s.t));
            end
            if (tick_a) begin
                if (q.size() == 0) begin
                    check("unexpected_step", 64'(tick_a), 64'(0));
                end else begin
                    s = q.pop_front();
                    check("step_time", 64'(longint'($time) - 5), 64'(s.t));
                    check("step_led", 64'(led_a), 64'(s.led));
                    check("step_wrap", 64'(wrap_a), 64'(s.w));
                end
            end else begin
                check("wrap_idle", 64'(wrap_a), 64'(0));
            end
            check("tick_b", 64'(tick_b), 64'(tick_a));
        end
    end

    initial begin
        logic       e;
        logic [1:0] md;

        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_led_a", 64'(led_a), 64'(0));
        check("rst_led_b", 64'(led_b), 64'hF);
        check("rst_tick", 64'(tick_a), 64'(0));
        check("rst_wrap", 64'(wrap_a), 64'(0));
        rst_n = 1'b1;

        // Each mode through more than one full cycle.
        repeat (20) step(1'b1, 2'd0);
        repeat (24) step(1'b1, 2'd1);
        repeat (32) step(1'b1, 2'd2);
        repeat (28) step(1'b1, 2'd3);

        // Pause at cnt==2 for 10 clocks, then resume.
        for (int i = 0; i < 50 && !(m_mode_q == 0 && m_cnt == 2); i++) step(1'b1, 2'd0);
        check("reach_cnt2", 64'(m_cnt), 64'(2));
        repeat (10) step(1'b0, 2'd0);
        repeat (10) step(1'b1, 2'd0);

        // Mode change 0 -> 2 while showing 0100.
        for (int i = 0; i < 50 && m_led != 4'b0100; i++) step(1'b1, 2'd0);
        check("reach_0100", 64'(led_a), 64'(4'b0100));
        step(1'b1, 2'd2);
        check("modechg_clear", 64'(led_a), 64'(0));
        repeat (8) step(1'b1, 2'd2);

        // Mode change colliding with a step.
        for (int i = 0; i < 50 && m_cnt != int'(CM); i++) step(1'b1, 2'd2);
        check("reach_cntmax", 64'(m_cnt), 64'(CM));
        step(1'b1, 2'd3);
        check("collide_tick", 64'(tick_a), 64'(0));
        check("collide_led", 64'(led_a), 64'(0));
        repeat (8) step(1'b1, 2'd3);

        // Randomized enable and mode traffic.
        md = 2'd3;
        for (int i = 0; i < 1500; i++) begin
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) md = 2'($urandom_range(0, 3));
            step(e, md);
        end

        // Asynchronous reset in the middle of a step period.
        for (int i = 0; i < 60 && !(m_mode_q == 0 && m_led == 4'b1000 && m_cnt == 1); i++)
            step(1'b1, 2'd0);
        check("reach_mid", 64'(led_a), 64'(4'b1000));
        #2;
        rst_n = 1'b0;
        q.delete();
        model_reset();
        #1;
        check("async_led_a", 64'(led_a), 64'(0));
        check("async_led_b", 64'(led_b), 64'hF);
        check("async_tick", 64'(tick_a), 64'(0));
        check("async_wrap", 64'(wrap_a), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) step(1'b1, 2'd0);

        repeat (2) step(1'b0, 2'd0);
        @(negedge clk);
        #1;
        check("queue_drained", 64'(q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
